// File: rtl/i2c_xfer_sched.sv
// Round-robin transaction scheduler that turns register-style read/write requests into
// START/WR/RD/STOP byte commands. Define I2C_XFER_SCHED_TIMEOUT_EN to add a per-command watchdog.
module i2c_xfer_sched #(
    parameter int REQ_NUM     = 2,
    parameter int PTR_W       = $clog2(REQ_NUM),
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [REQ_NUM-1:0]   req_i,
    input  logic [REQ_NUM-1:0]   rd_i,
    input  logic [REQ_NUM*7-1:0] dev_i,
    input  logic [REQ_NUM*8-1:0] reg_i,
    input  logic [REQ_NUM*8-1:0] wdat_i,
    output logic [REQ_NUM-1:0]   gnt_o,
    output logic [REQ_NUM-1:0]   done_o,
    output logic [1:0]           err_o,
    output logic [7:0]           rdata_o,
    output logic                 busy_o,
    output logic                 bc_sta_o,
    output logic                 bc_sto_o,
    output logic                 bc_rd_o,
    output logic                 bc_wr_o,
    output logic                 bc_ack_o,
    output logic [7:0]           bc_txr_o,
    input  logic                 bc_done_i,
    input  logic                 bc_rxack_i,
    input  logic                 bc_al_i,
    input  logic [7:0]           bc_rxr_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVW, S_REGA, S_WDAT, S_RSTA, S_RDAT, S_STOP, S_RESP
    } state_t;

    typedef struct packed {
        logic       sta;
        logic       sto;
        logic       rd;
        logic       wr;
        logic       ack;
        logic [7:0] txr;
    } cmd_t;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_AL   = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    state_t             state;
    state_t             done_nxt;
    cmd_t               cmd_q;
    cmd_t               state_cmd;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic               win_found;
    logic [REQ_NUM-1:0] win_oh;
    logic [6:0]         dev_q;
    logic [7:0]         reg_q;
    logic [7:0]         wdat_q;
    logic               rd_q;
    logic [1:0]         err_q;
    logic [1:0]         done_err;
    logic               cmd_act;
    logic               tmo_hit;

    // Every command carries at least one control bit, so a non-empty command means one is in flight.
    assign cmd_act  = cmd_q.sta | cmd_q.sto | cmd_q.rd | cmd_q.wr | cmd_q.ack;
    assign busy_o   = (state != S_IDLE);
    assign bc_sta_o = cmd_q.sta;
    assign bc_sto_o = cmd_q.sto;
    assign bc_rd_o  = cmd_q.rd;
    assign bc_wr_o  = cmd_q.wr;
    assign bc_ack_o = cmd_q.ack;
    assign bc_txr_o = cmd_q.txr;

    // Search starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        win       = ptr;
        cand      = ptr;
        win_found = 1'b0;
        win_oh    = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            cand = PTR_W'((int'(ptr) + i) % REQ_NUM);
            if (!win_found && req_i[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
        win_oh[win] = 1'b1;
    end

    always_comb begin
        state_cmd = '0;
        case (state)
            S_DEVW: begin
                state_cmd.sta = 1'b1;
                state_cmd.wr  = 1'b1;
                state_cmd.txr = {dev_q, 1'b0};
            end
            S_REGA: begin
                state_cmd.wr  = 1'b1;
                state_cmd.txr = reg_q;
            end
            S_WDAT: begin
                state_cmd.wr  = 1'b1;
                state_cmd.sto = 1'b1;
                state_cmd.txr = wdat_q;
            end
            S_RSTA: begin
                state_cmd.sta = 1'b1;
                state_cmd.wr  = 1'b1;
                state_cmd.txr = {dev_q, 1'b1};
            end
            S_RDAT: begin
                state_cmd.rd  = 1'b1;
                state_cmd.ack = 1'b1;
                state_cmd.sto = 1'b1;
            end
            S_STOP:  state_cmd.sto = 1'b1;
            default: state_cmd = '0;
        endcase
    end

    // Where a successful or NACKed byte command leads; STOP keeps the status it was entered with.
    always_comb begin
        done_nxt = S_RESP;
        done_err = err_q;
        case (state)
            S_DEVW: begin
                done_nxt = bc_rxack_i ? S_STOP : S_REGA;
                done_err = bc_rxack_i ? ERR_NACK : ERR_OK;
            end
            S_REGA: begin
                done_nxt = bc_rxack_i ? S_STOP : (rd_q ? S_RSTA : S_WDAT);
                done_err = bc_rxack_i ? ERR_NACK : ERR_OK;
            end
            S_WDAT: begin
                done_nxt = S_RESP;
                done_err = bc_rxack_i ? ERR_NACK : ERR_OK;
            end
            S_RSTA: begin
                done_nxt = bc_rxack_i ? S_STOP : S_RDAT;
                done_err = bc_rxack_i ? ERR_NACK : ERR_OK;
            end
            S_RDAT: begin
                done_nxt = S_RESP;
                done_err = ERR_OK;
            end
            default: begin
                done_nxt = S_RESP;
                done_err = err_q;
            end
        endcase
    end

`ifdef I2C_XFER_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

    logic [15:0] tmo_cnt;

    assign tmo_hit = cmd_act && (tmo_cnt == TMO_LIM);

    always_ff @(posedge clk_i) begin
        if (rst_i || !cmd_act) begin
            tmo_cnt <= '0;
        end else if (!bc_done_i && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    // No watchdog is built; the comparison folds to a constant 0 for any legal limit.
    assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the latched request fields are reset too, so nothing downstream ever sees X.
            state   <= S_IDLE;
            ptr     <= PTR_W'(REQ_NUM - 1);
            gnt_o   <= '0;
            done_o  <= '0;
            err_o   <= ERR_OK;
            rdata_o <= '0;
            cmd_q   <= '0;
            err_q   <= ERR_OK;
            rd_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdat_q  <= '0;
        end else begin
            done_o <= '0;
            case (state)
                S_IDLE: begin
                    if (en_i && win_found) begin
                        gnt_o  <= win_oh;
                        ptr    <= win;
                        rd_q   <= rd_i[win];
                        dev_q  <= dev_i[7*int'(win) +: 7];
                        reg_q  <= reg_i[8*int'(win) +: 8];
                        wdat_q <= wdat_i[8*int'(win) +: 8];
                        err_q  <= ERR_OK;
                        state  <= S_DEVW;
                    end
                end
                S_RESP: begin
                    gnt_o <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    if (bc_al_i) begin
                        // Bus is lost: no STOP, report straight away.
                        cmd_q  <= '0;
                        state  <= S_RESP;
                        done_o <= gnt_o;
                        err_o  <= ERR_AL;
                    end else if (!cmd_act) begin
                        cmd_q <= state_cmd;
                    end else if (bc_done_i) begin
                        cmd_q <= '0;
                        state <= done_nxt;
                        err_q <= done_err;
                        if (done_nxt == S_RESP) begin
                            done_o <= gnt_o;
                            err_o  <= done_err;
                        end
                        if (state == S_RDAT) begin
                            rdata_o <= bc_rxr_i;
                        end
                    end else if (tmo_hit) begin
                        cmd_q <= '0;
                        err_q <= ERR_TMO;
                        if (state == S_STOP) begin
                            state  <= S_RESP;
                            done_o <= gnt_o;
                            err_o  <= ERR_TMO;
                        end else begin
                            state <= S_STOP;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Scoreboard bench for i2c_xfer_sched: a byte-engine model checks each command against an
// expected queue, and every done_o is compared against the expected completion queue.
module tb_i2c_xfer_sched;

    localparam int REQ_NUM = 2;

    localparam logic [12:0] C_STAWR = 13'h1200;
    localparam logic [12:0] C_WR    = 13'h0200;
    localparam logic [12:0] C_WRSTO = 13'h0A00;
    localparam logic [12:0] C_STO   = 13'h0800;
    localparam logic [12:0] C_RDAT  = 13'h0D00;

    typedef struct {
        logic [1:0] owner;
        logic [1:0] err;
        logic [7:0] rdata;
        logic       rd;
    } res_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 en_i  = 1'b1;
    logic [REQ_NUM-1:0]   req_i = '0;
    logic [REQ_NUM-1:0]   rd_i  = '0;
    logic [REQ_NUM*7-1:0] dev_i = '0;
    logic [REQ_NUM*8-1:0] reg_i = '0;
    logic [REQ_NUM*8-1:0] wdat_i = '0;
    logic [REQ_NUM-1:0]   gnt_o;
    logic [REQ_NUM-1:0]   done_o;
    logic [1:0]           err_o;
    logic [7:0]           rdata_o;
    logic                 busy_o;
    logic                 bc_sta_o, bc_sto_o, bc_rd_o, bc_wr_o, bc_ack_o;
    logic [7:0]           bc_txr_o;
    logic                 bc_done_i  = 1'b0;
    logic                 bc_rxack_i = 1'b0;
    logic                 bc_al_i    = 1'b0;
    logic [7:0]           bc_rxr_i   = '0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    int last_pulse_cyc = 0;
    int cmd_idx = 0;
    int wait_cnt = 0;
    int nack_at = -1;
    int al_at = -1;
    int hold_at = -1;
    bit seen = 1'b0;
    bit pulsed = 1'b0;
    bit al_chk = 1'b0;
    logic [7:0] rx_byte = '0;
    logic [REQ_NUM-1:0] prev_gnt = '0;
    logic prev_busy = 1'b0;

    logic [12:0] cmd_q[$];
    logic [1:0]  gnt_q[$];
    res_t        res_q[$];

    i2c_xfer_sched #(.REQ_NUM(REQ_NUM)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .req_i(req_i), .rd_i(rd_i),
        .dev_i(dev_i), .reg_i(reg_i), .wdat_i(wdat_i), .gnt_o(gnt_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .bc_sta_o(bc_sta_o), .bc_sto_o(bc_sto_o), .bc_rd_o(bc_rd_o), .bc_wr_o(bc_wr_o),
        .bc_ack_o(bc_ack_o), .bc_txr_o(bc_txr_o), .bc_done_i(bc_done_i),
        .bc_rxack_i(bc_rxack_i), .bc_al_i(bc_al_i), .bc_rxr_i(bc_rxr_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_fields(input int who, input logic rd, input logic [6:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd);
        rd_i[who]          = rd;
        dev_i[7*who +: 7]  = dev;
        reg_i[8*who +: 8]  = rg;
        wdat_i[8*who +: 8] = wd;
    endtask

    // Pushes the command sequence, grant and completion one transaction should produce.
    task automatic plan(input int who, input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input int nack, input int al, input logic [7:0] rx);
        logic [12:0] seq[4];
        int          n;
        int          last;
        res_t        r;
        seq[0] = C_STAWR | 13'({dev, 1'b0});
        seq[1] = C_WR | 13'(rg);
        seq[2] = rd ? (C_STAWR | 13'({dev, 1'b1})) : (C_WRSTO | 13'(wd));
        seq[3] = C_RDAT;
        n      = rd ? 4 : 3;
        last   = n - 1;
        r.err  = 2'd0;
        if (nack >= 0) begin
            last  = nack;
            r.err = 2'd1;
        end
        if (al >= 0) begin
            last  = al;
            r.err = 2'd2;
        end
        for (int i = 0; i <= last; i++) cmd_q.push_back(seq[i]);
        if (r.err == 2'd1 && !(!rd && nack == 2)) cmd_q.push_back(C_STO);
        r.owner = 2'(1 << who);
        r.rdata = rx;
        r.rd    = rd;
        gnt_q.push_back(2'(1 << who));
        res_q.push_back(r);
    endtask

    task automatic wait_done(input int n);
        int got = 0;
        for (int i = 0; i < 400 * n && got < n; i++) begin
            @(negedge clk_i);
            if (done_o != '0) got++;
        end
        check("done_wait", got, n);
    endtask

    // Byte-engine model: checks each new command, then answers after a short random delay.
    always @(negedge clk_i) begin
        logic [12:0] cmd_obs;
        logic [12:0] e;
        logic [12:0] m;
        bc_done_i  = 1'b0;
        bc_al_i    = 1'b0;
        bc_rxack_i = 1'b0;
        bc_rxr_i   = rx_byte;
        cmd_obs    = {bc_sta_o, bc_sto_o, bc_rd_o, bc_wr_o, bc_ack_o, bc_txr_o};
        if (al_chk) begin
            check("al_cmd_clear", cmd_obs, 0);
            al_chk = 1'b0;
        end
        if (gnt_o == '0) cmd_idx = 0;
        if (cmd_obs[12:8] == 5'd0) begin
            seen   = 1'b0;
            pulsed = 1'b0;
        end else if (!seen) begin
            seen     = 1'b1;
            wait_cnt = $urandom_range(0, 2);
            if (cmd_idx == 0) check("gnt_to_cmd", cyc, gnt_cyc + 1);
            if (cmd_q.size() == 0) begin
                check("cmd_extra", cmd_obs, 0);
            end else begin
                e = cmd_q.pop_front();
                m = e[9] ? 13'h1FFF : 13'h1F00;
                check("cmd", cmd_obs & m, e & m);
            end
        end
        if (seen && !pulsed) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else if (cmd_idx != hold_at) begin
                if (cmd_idx == al_at) begin
                    bc_al_i = 1'b1;
                    al_chk  = 1'b1;
                end else begin
                    bc_done_i  = 1'b1;
                    bc_rxack_i = (cmd_idx == nack_at);
                end
                last_pulse_cyc = cyc;
                pulsed         = 1'b1;
                cmd_idx++;
            end
        end
    end

    // Grant and completion monitor.
    always @(negedge clk_i) begin
        res_t r;
        if (rst_i) begin
            prev_gnt  = '0;
            prev_busy = 1'b0;
        end else begin
            if (gnt_o != '0 && gnt_o != prev_gnt) begin
                check("gnt_onehot", $countones(gnt_o), 1);
                check("idle_gap", prev_busy, 0);
                if (gnt_q.size() == 0) check("gnt_extra", gnt_o, 0);
                else check("gnt_order", gnt_o, gnt_q.pop_front());
                gnt_cyc = cyc;
            end
            if (done_o != '0) begin
                check("done_latency", cyc, last_pulse_cyc + 1);
                if (res_q.size() == 0) begin
                    check("done_extra", done_o, 0);
                end else begin
                    r = res_q.pop_front();
                    check("done_owner", done_o, r.owner);
                    check("err", err_o, r.err);
                    if (r.rd && r.err == 2'd0) check("rdata", rdata_o, r.rdata);
                end
            end
            prev_gnt  = gnt_o;
            prev_busy = busy_o;
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({gnt_o, done_o, err_o, rdata_o, busy_o, bc_sta_o, bc_sto_o,
                    bc_rd_o, bc_wr_o, bc_ack_o, bc_txr_o});
    endfunction

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_outs", all_outs(), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single write from requester 0.
        set_fields(0, 1'b0, 7'h50, 8'h12, 8'hA5);
        plan(0, 1'b0, 7'h50, 8'h12, 8'hA5, -1, -1, 8'h00);
        req_i = 2'b01;
        @(negedge clk_i);
        check("req_to_gnt", gnt_o, 2'b01);
        wait_done(1);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);

        // Single read from requester 1.
        rx_byte = 8'h3C;
        set_fields(1, 1'b1, 7'h68, 8'h75, 8'h00);
        plan(1, 1'b1, 7'h68, 8'h75, 8'h00, -1, -1, 8'h3C);
        req_i = 2'b10;
        wait_done(1);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);

        // Round-robin with both requesting continuously from reset.
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        set_fields(0, 1'b0, 7'h21, 8'h01, 8'h11);
        set_fields(1, 1'b0, 7'h22, 8'h02, 8'h22);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) plan(0, 1'b0, 7'h21, 8'h01, 8'h11, -1, -1, 8'h00);
            else plan(1, 1'b0, 7'h22, 8'h02, 8'h22, -1, -1, 8'h00);
        end
        req_i = 2'b11;
        wait_done(4);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);

        // NACK on the device address byte.
        nack_at = 0;
        set_fields(0, 1'b0, 7'h50, 8'h12, 8'hA5);
        plan(0, 1'b0, 7'h50, 8'h12, 8'hA5, 0, -1, 8'h00);
        req_i = 2'b01;
        wait_done(1);
        req_i   = 2'b00;
        nack_at = -1;
        repeat (2) @(negedge clk_i);

        // Arbitration lost during the register address byte.
        al_at = 1;
        set_fields(1, 1'b0, 7'h33, 8'h44, 8'h55);
        plan(1, 1'b0, 7'h33, 8'h44, 8'h55, -1, 1, 8'h00);
        req_i = 2'b10;
        wait_done(1);
        req_i = 2'b00;
        al_at = -1;
        repeat (2) @(negedge clk_i);

        // Reset in the middle of a read data byte.
        hold_at = 3;
        set_fields(1, 1'b1, 7'h68, 8'h75, 8'h00);
        cmd_q.push_back(C_STAWR | 13'h00D0);
        cmd_q.push_back(C_WR | 13'h0075);
        cmd_q.push_back(C_STAWR | 13'h00D1);
        cmd_q.push_back(C_RDAT);
        gnt_q.push_back(2'b10);
        req_i = 2'b10;
        for (int i = 0; i < 200 && !bc_rd_o; i++) @(negedge clk_i);
        check("rd_cmd_seen", bc_rd_o, 1);
        rst_i = 1'b1;
        req_i = 2'b00;
        @(negedge clk_i);
        check("midxfer_reset_outs", all_outs(), 0);
        hold_at = -1;
        rst_i   = 1'b0;

        // Enable gating, then en_i dropped mid-transaction.
        en_i = 1'b0;
        set_fields(0, 1'b0, 7'h0F, 8'hF0, 8'h5A);
        req_i = 2'b01;
        repeat (4) begin
            @(negedge clk_i);
            check("gnt_while_disabled", gnt_o, 0);
        end
        plan(0, 1'b0, 7'h0F, 8'hF0, 8'h5A, -1, -1, 8'h00);
        en_i = 1'b1;
        @(negedge clk_i);
        check("gnt_on_enable", gnt_o, 2'b01);
        en_i = 1'b0;
        wait_done(1);
        req_i = 2'b00;
        en_i  = 1'b1;
        repeat (3) @(negedge clk_i);

        check("cmd_q_left", cmd_q.size(), 0);
        check("gnt_q_left", gnt_q.size(), 0);
        check("res_q_left", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_xfer_sched.md
Name: i2c_xfer_sched

Overview:
- Transaction scheduler in front of the I2C byte-level command engine; replaces software writes to the CMD/TXR registers for register-style accesses.
- Arbitrates round-robin among REQ_NUM on-chip requesters.
- Sequences each granted request into START/WR/RD/STOP byte commands, collects ACK, arbitration-lost and read data, and returns a per-requester completion with a status code.

Parameters:
- REQ_NUM, 2, number of requesters (2..8)
- PTR_W, $clog2(REQ_NUM), round-robin pointer width (derived; do not override)
- TIMEOUT_CYC, 65535, watchdog limit in clk_i cycles per byte command (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  scheduler enable; low blocks new grants
- req_i  in  REQ_NUM  per-requester request level
- rd_i  in  REQ_NUM  1 = register read, 0 = register write
- dev_i  in  REQ_NUM*7  7-bit device address per requester (slice n = [7n+6:7n])
- reg_i  in  REQ_NUM*8  register address per requester
- wdat_i  in  REQ_NUM*8  write data per requester
- gnt_o  out  REQ_NUM  one-hot, high for the whole owned transaction
- done_o  out  REQ_NUM  one-cycle completion pulse to the owner
- err_o  out  2  status, valid with done_o: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout
- rdata_o  out  8  read byte; valid with done_o when rd and err_o==0; holds until next done
- busy_o  out  1  high in any state other than IDLE
- bc_sta_o, bc_sto_o, bc_rd_o, bc_wr_o, bc_ack_o  out  1 each  byte-engine command bits (STA, STO, RD, WR, ACK)
- bc_txr_o  out  8  byte to transmit
- bc_done_i  in  1  byte-engine command-complete pulse
- bc_rxack_i  in  1  received ACK bit (1 = NACK)
- bc_al_i  in  1  arbitration-lost pulse
- bc_rxr_i  in  8  received byte

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - RR pointer = REQ_NUM-1, so requester 0 has first priority.
  - A reset mid-transaction drops all commands immediately. No STOP is issued and no done_o is raised.
- Arbitration:
  - In IDLE with en_i=1 and |req_i, pick the first set req starting at ptr+1 and wrapping.
  - Next cycle: gnt_o is set, request fields are latched, ptr becomes the winner, and the state goes to DEVW.
  - Request fields are sampled only at grant.
  - Requesters hold req_i until done_o and drop it the cycle after. A req_i still high in IDLE is a new request.
- Command handshake:
  - Exactly one command set is driven per state, registered and held stable until bc_done_i.
  - The cycle after bc_done_i, all command bits clear or the next state's command appears.
  - bc_al_i takes priority over bc_done_i in the same cycle.
- States and commands:
  - DEVW: STA+WR, txr={dev,0}.
  - REGA: WR, txr=reg.
  - WDAT (write only): WR+STO, txr=wdat.
  - RSTA (read only): STA+WR, txr={dev,1}.
  - RDAT: RD+ACK+STO; ACK=1 sends NACK on the last byte. Capture bc_rxr_i into rdata_o at bc_done_i.
  - STOP: STO only.
  - RESP: one-cycle done_o[owner]=1, gnt_o cleared, then IDLE. Minimum of 1 IDLE cycle between transactions.
- Transitions:
  - DEVW→REGA→(rd ? RSTA→RDAT : WDAT)→RESP.
  - bc_rxack_i=1 at bc_done_i in DEVW, REGA, WDAT or RSTA: err=1. Go to STOP, except WDAT, which already carries STO and goes to RESP.
  - bc_al_i in any active state: err=2. Drop commands and go to RESP directly; no STOP, because the bus is lost.
  - STOP→RESP on bc_done_i.
- en_i falling mid-transaction has no effect until return to IDLE.
- Latencies:
  - From req_i to gnt_o: 1 cycle.
  - From gnt_o to first command: 1 cycle.
  - From the final bc_done_i to done_o: 1 cycle.

Optional Feature:
- I2C_XFER_SCHED_TIMEOUT_EN defined:
  - A 16-bit per-command counter clears on each new command and increments while waiting for bc_done_i.
  - On reaching TIMEOUT_CYC: err=3, command bits clear, STOP is attempted, then RESP.
  - If the STOP itself times out, go straight to RESP.
- Undefined: no counter is built, and err_o never equals 3.

Test Plan:
- Write, single requester: req0, dev=0x50, reg=0x12, wdat=0xA5, engine ACKs all. Expect:
  - command sequence STA+WR 0xA0, WR 0x12, WR+STO 0xA5
  - done_o=01 and err_o=0, one cycle after the third bc_done_i
- Read: req1, rd=1, dev=0x68, reg=0x75, engine returns 0x3C. Expect:
  - command sequence STA+WR 0xD0, WR 0x75, STA+WR 0xD1, RD+ACK+STO
  - rdata_o=0x3C, err_o=0, done_o=10
- Round-robin: req_i=11 continuously from reset. Expect:
  - grants in order 0,1,0,1
  - gnt_o never two-hot
  - at least 1 IDLE cycle between grants
- NACK on device address: rxack=1 at the first done. Expect:
  - STO-only command issued
  - done with err_o=1, no REGA command
- Arbitration lost during REGA: bc_al_i pulse. Expect:
  - all bc_* commands low the next cycle
  - done with err_o=2, no STO issued
- Reset and enable: assert rst_i during RDAT, then test en_i. Expect:
  - all outputs 0 the next cycle
  - with en_i=0 and req_i=01 after reset, gnt_o stays 0 until en_i=1
